// File: rtl/i2c_slave.sv
// I2C target at a fixed 7-bit address. SDA is open-drain via i2c_sda_oe; SCL is input-only.
// Latency: 3 clk from pin edge to action (5 clk when I2C_SLAVE_GLITCH_FILTER_EN is defined).
// Backpressure: none. SCL is never stretched; the client takes rx_valid bytes and supplies data_slave on tx_load.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1100110
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_scl,
  input  logic       i2c_sda_in,
  output logic       i2c_sda_oe,
  input  logic [7:0] data_slave,
  output logic [7:0] data_master,
  output logic       rx_valid,
  output logic       tx_load,
  output logic       rw,
  output logic       busy
);
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] scl_sync, sda_sync;
  logic       scl, sda, scl_d, sda_d;
  logic       scl_rise, scl_fall, start_c, stop_c;
  logic [2:0] bit_cnt, cnt_nxt;
  logic       full, full_nxt;
  logic [7:0] shreg, sh_nxt, txsh, tx_nxt, dm_nxt;
  logic       oe_nxt, rxv_nxt, txl_nxt, rw_nxt, busy_nxt;

  // two-flop synchronizers; reset to idle-bus level so no edge appears at reset release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], i2c_scl};
      sda_sync <= {sda_sync[0], i2c_sda_in};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;
  logic       scl_filt, sda_filt;

  // majority of three consecutive synced samples rejects single-cycle pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_filt <= 1'b1;
      sda_filt <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      scl_filt <= (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
      sda_filt <= (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
    end
  end

  assign scl = scl_filt;
  assign sda = sda_filt;
`else
  assign scl = scl_sync[1];
  assign sda = sda_sync[1];
`endif

  // previous-cycle copies for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl;
      sda_d <= sda;
    end
  end

  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  assign start_c  = scl & sda_d & ~sda;
  assign stop_c   = scl & ~sda_d & sda;

  // state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      full        <= 1'b0;
      shreg       <= 8'h00;
      txsh        <= 8'h00;
      i2c_sda_oe  <= 1'b0;
      data_master <= 8'h00;
      rx_valid    <= 1'b0;
      tx_load     <= 1'b0;
      rw          <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= cnt_nxt;
      full        <= full_nxt;
      shreg       <= sh_nxt;
      txsh        <= tx_nxt;
      i2c_sda_oe  <= oe_nxt;
      data_master <= dm_nxt;
      rx_valid    <= rxv_nxt;
      tx_load     <= txl_nxt;
      rw          <= rw_nxt;
      busy        <= busy_nxt;
    end
  end

  // next-state and outputs; START/STOP take priority over any SCL edge in the same cycle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    full_nxt  = full;
    sh_nxt    = shreg;
    tx_nxt    = txsh;
    oe_nxt    = i2c_sda_oe;
    dm_nxt    = data_master;
    rxv_nxt   = 1'b0;
    txl_nxt   = 1'b0;
    rw_nxt    = rw;
    busy_nxt  = busy;
    if (stop_c) begin
      state_nxt = IDLE;
      oe_nxt    = 1'b0;
      busy_nxt  = 1'b0;
    end else if (start_c) begin
      state_nxt = ADDR;
      oe_nxt    = 1'b0;
      busy_nxt  = 1'b0;
      cnt_nxt   = 3'd0;
      full_nxt  = 1'b0;
    end else begin
      case (state)
        ADDR, WR_DATA: begin
          // full marks that the 8th bit has been shifted; the byte is acted on at the next SCL fall
          if (scl_rise) begin
            sh_nxt  = {shreg[6:0], sda};
            cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) full_nxt = 1'b1;
          end else if (scl_fall && full) begin
            full_nxt = 1'b0;
            if (state == ADDR) begin
              if (shreg[7:1] == SLAVE_ADDR) begin
                rw_nxt    = shreg[0];
                oe_nxt    = 1'b1;
                busy_nxt  = 1'b1;
                state_nxt = ADDR_ACK;
              end else begin
                state_nxt = IGNORE;
              end
            end else begin
              dm_nxt    = shreg;
              rxv_nxt   = 1'b1;
              oe_nxt    = 1'b1;
              state_nxt = WR_ACK;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            oe_nxt  = 1'b0;
            cnt_nxt = 3'd0;
            if (rw) begin
              txl_nxt   = 1'b1;
              tx_nxt    = data_slave;
              oe_nxt    = ~data_slave[7];
              state_nxt = RD_DATA;
            end else begin
              state_nxt = WR_DATA;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            oe_nxt    = 1'b0;
            cnt_nxt   = 3'd0;
            state_nxt = WR_DATA;
          end
        end
        RD_DATA: begin
          // the MSB is already on the bus; each fall presents the next bit, the 8th fall releases
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              oe_nxt    = 1'b0;
              cnt_nxt   = 3'd0;
              full_nxt  = 1'b0;
              state_nxt = RD_ACK;
            end else begin
              tx_nxt  = {txsh[6:0], 1'b0};
              oe_nxt  = ~txsh[6];
              cnt_nxt = bit_cnt + 3'd1;
            end
          end
        end
        RD_ACK: begin
          // here full remembers that the master ACKed on the preceding rise
          if (scl_rise) begin
            if (sda) begin
              state_nxt = IGNORE;
              busy_nxt  = 1'b0;
            end else begin
              full_nxt = 1'b1;
            end
          end else if (scl_fall && full) begin
            full_nxt  = 1'b0;
            txl_nxt   = 1'b1;
            tx_nxt    = data_slave;
            oe_nxt    = ~data_slave[7];
            cnt_nxt   = 3'd0;
            state_nxt = RD_DATA;
          end
        end
        IGNORE: begin
          oe_nxt   = 1'b0;
          busy_nxt = 1'b0;
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_slave.sv
`timescale 1ns/1ps
// Bench for i2c_slave: a bit-level I2C master drives the pins over a wired-AND SDA line.
// Expected bytes, ACKs and pulse counts come from the transaction description itself.
module tb_i2c_slave;
  localparam logic [6:0] MY_ADDR = 7'h66;
  localparam int LO = 10;
  localparam int HI = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [7:0] data_slave = 8'h00;
  logic       sda_oe;
  logic [7:0] data_master;
  logic       rx_valid, tx_load, rw, busy;
  wire        sda_line = m_sda & ~sda_oe;

  i2c_slave dut (
    .clk(clk), .reset(reset), .i2c_scl(scl), .i2c_sda_in(sda_line),
    .i2c_sda_oe(sda_oe), .data_slave(data_slave), .data_master(data_master),
    .rx_valid(rx_valid), .tx_load(tx_load), .rw(rw), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // bus monitor: only this process writes these
  logic [7:0] rxq[$];
  int txl_cnt = 0, oe_cnt = 0, long_pulse = 0;
  logic rxv_prev = 1'b0, txl_prev = 1'b0;
  always @(negedge clk) begin
    if (rx_valid) rxq.push_back(data_master);
    if (tx_load) txl_cnt++;
    if (sda_oe) oe_cnt++;
    if ((rx_valid && rxv_prev) || (tx_load && txl_prev)) long_pulse++;
    rxv_prev = rx_valid;
    txl_prev = tx_load;
  end

  typedef struct {
    logic [6:0]      a;
    logic            rd;
    int              n;
    logic [3:0][7:0] d;
    logic            exp_ack;
    int              exp_rx;
  } vec_t;

  function automatic vec_t mk(logic [6:0] a, logic rd, int n, logic [31:0] d, logic ea, int erx);
    vec_t v;
    v.a = a; v.rd = rd; v.n = n; v.d = d; v.exp_ack = ea; v.exp_rx = erx;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one SCL clock with SCL low on entry and exit; optional 1-clk low glitch in the high phase
  task automatic bit_cycle(input logic b, input logic glitch, output logic s);
    wclk(3); m_sda = b; wclk(LO - 3);
    scl = 1'b1; wclk(3);
    if (glitch) begin scl = 1'b0; wclk(1); scl = 1'b1; wclk(1); end
    else wclk(2);
    s = sda_line; wclk(HI - 5);
    scl = 1'b0;
  endtask

  task automatic start_cond();
    if (scl == 1'b0) begin wclk(3); m_sda = 1'b1; wclk(LO - 3); scl = 1'b1; end
    wclk(HI); m_sda = 1'b0; wclk(HI); scl = 1'b0;
  endtask

  task automatic stop_cond();
    wclk(3); m_sda = 1'b0; wclk(LO - 3); scl = 1'b1; wclk(HI); m_sda = 1'b1; wclk(HI);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gbit, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], i == gbit, s);
    bit_cycle(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic ack_it, input logic [7:0] next_ds, output logic [7:0] got);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, 1'b0, s);
      got[i] = s;
      if (i == 4) data_slave = next_ds;
    end
    bit_cycle(~ack_it, 1'b0, s);
  endtask

  // complete START..STOP transaction; reads ACK every byte but the last
  task automatic run_txn(input string nm, input vec_t v);
    logic ack;
    logic [7:0] got;
    int rx0, tx0, oe0, lp0;
    logic match;
    match = v.exp_ack;
    rx0 = rxq.size(); tx0 = txl_cnt; oe0 = oe_cnt; lp0 = long_pulse;
    data_slave = v.d[0];
    start_cond();
    send_byte({v.a, v.rd}, -1, ack);
    chk({nm, ".addr_ack"}, ack, v.exp_ack);
    chk({nm, ".busy_after_addr"}, busy, match);
    if (match) chk({nm, ".rw"}, rw, v.rd);
    for (int k = 0; k < v.n; k++) begin
      if (match && v.rd) begin
        recv_byte(k != v.n - 1, (k + 1 < v.n) ? v.d[k + 1] : 8'hFF, got);
        chk({nm, ".rd_byte"}, got, v.d[k]);
      end else begin
        send_byte(v.d[k], -1, ack);
        chk({nm, ".data_ack"}, ack, match);
      end
    end
    chk({nm, ".busy_before_stop"}, busy, match && !v.rd);
    stop_cond();
    wclk(4);
    chk({nm, ".busy_after_stop"}, busy, 1'b0);
    chk({nm, ".oe_after_stop"}, sda_oe, 1'b0);
    chk({nm, ".rx_count"}, rxq.size() - rx0, v.exp_rx);
    for (int k = 0; k < v.exp_rx && rx0 + k < rxq.size(); k++)
      chk({nm, ".rx_byte"}, rxq[rx0 + k], v.d[k]);
    chk({nm, ".tx_load_count"}, txl_cnt - tx0, (match && v.rd) ? v.n : 0);
    chk({nm, ".pulse_width"}, long_pulse - lp0, 0);
    if (!match) chk({nm, ".oe_never"}, oe_cnt - oe0, 0);
  endtask

  initial begin
    vec_t tbl[6];
    vec_t rv;
    logic ack, s;
    logic [7:0] got;
    logic [7:0] e_glitch;
    int rx0, oe0, tx0;

    tbl[0] = mk(7'h66, 1'b0, 1, 32'h0000_00E7, 1'b1, 1);
    tbl[1] = mk(7'h66, 1'b1, 2, 32'h0000_55AA, 1'b1, 0);
    tbl[2] = mk(7'h55, 1'b0, 1, 32'h0000_00E7, 1'b0, 0);
    tbl[3] = mk(7'h66, 1'b0, 3, 32'h005A_FF00, 1'b1, 3);
    tbl[4] = mk(7'h66, 1'b1, 1, 32'h0000_0000, 1'b1, 0);
    tbl[5] = mk(7'h12, 1'b1, 1, 32'h0000_0033, 1'b0, 0);

    #1 reset = 1'b1;
    wclk(3);
    chk("reset.oe", sda_oe, 1'b0);
    chk("reset.data_master", data_master, 8'h00);
    chk("reset.rx_valid", rx_valid, 1'b0);
    chk("reset.tx_load", tx_load, 1'b0);
    chk("reset.rw", rw, 1'b0);
    chk("reset.busy", busy, 1'b0);
    reset = 1'b0;
    wclk(5);

    for (int i = 0; i < 6; i++) run_txn($sformatf("tbl%0d", i), tbl[i]);

    // randomized transactions; expectations follow from address match and direction alone
    for (int i = 0; i < 14; i++) begin
      rv.a  = ($urandom_range(0, 2) != 0) ? MY_ADDR : 7'($urandom);
      rv.rd = 1'($urandom_range(0, 1));
      rv.n  = $urandom_range(1, 4);
      rv.d  = $urandom;
      rv.exp_ack = (rv.a == MY_ADDR);
      rv.exp_rx  = (rv.exp_ack && !rv.rd) ? rv.n : 0;
      run_txn($sformatf("rnd%0d", i), rv);
    end

    // write, 4 data bits, repeated START, read: partial byte dropped
    rx0 = rxq.size(); tx0 = txl_cnt;
    start_cond();
    send_byte({MY_ADDR, 1'b0}, -1, ack);
    chk("rs.addr_w_ack", ack, 1'b1);
    bit_cycle(1'b1, 1'b0, s); bit_cycle(1'b1, 1'b0, s);
    bit_cycle(1'b1, 1'b0, s); bit_cycle(1'b0, 1'b0, s);
    data_slave = 8'h3C;
    start_cond();
    send_byte({MY_ADDR, 1'b1}, -1, ack);
    chk("rs.addr_r_ack", ack, 1'b1);
    chk("rs.rw", rw, 1'b1);
    recv_byte(1'b0, 8'h00, got);
    chk("rs.rd_byte", got, 8'h3C);
    stop_cond(); wclk(4);
    chk("rs.no_rx_valid", rxq.size() - rx0, 0);
    chk("rs.tx_load_count", txl_cnt - tx0, 1);

    // reset while the target is pulling SDA low in a read byte
    data_slave = 8'h00;
    start_cond();
    send_byte({MY_ADDR, 1'b1}, -1, ack);
    chk("rst.addr_ack", ack, 1'b1);
    for (int i = 0; i < 3; i++) bit_cycle(1'b1, 1'b0, s);
    wclk(5);
    chk("rst.oe_before", sda_oe, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst.oe_same_cycle", sda_oe, 1'b0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.rw", rw, 1'b0);
    chk("rst.tx_load", tx_load, 1'b0);
    wclk(2);
    reset = 1'b0;
    rx0 = rxq.size(); oe0 = oe_cnt;
    for (int i = 0; i < 6; i++) bit_cycle(1'b1, 1'b0, s);
    send_byte({MY_ADDR, 1'b0}, -1, ack);
    chk("rst.ignored_ack", ack, 1'b0);
    chk("rst.ignored_oe", oe_cnt - oe0, 0);
    chk("rst.ignored_busy", busy, 1'b0);
    start_cond();
    send_byte({MY_ADDR, 1'b0}, -1, ack);
    chk("rst.new_addr_ack", ack, 1'b1);
    send_byte(8'h81, -1, ack);
    stop_cond(); wclk(4);
    chk("rst.rx_count", rxq.size() - rx0, 1);
    if (rxq.size() > rx0) chk("rst.rx_byte", rxq[rx0], 8'h81);

    // one-clk low glitch on SCL during the 4th data bit (a 0) of 0xE7
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    e_glitch = 8'hE7;
`else
    e_glitch = 8'hE3;
`endif
    rx0 = rxq.size();
    start_cond();
    send_byte({MY_ADDR, 1'b0}, -1, ack);
    chk("glitch.addr_ack", ack, 1'b1);
    send_byte(8'hE7, 4, ack);
    stop_cond(); wclk(4);
    chk("glitch.rx_count", rxq.size() - rx0, 1);
    if (rxq.size() > rx0) chk("glitch.rx_byte", rxq[rx0], e_glitch);
    else chk("glitch.rx_present", 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
